ttc_chanb_cmd_receiver: RTL and testbench
=========================================

# ttc_chanb_cmd_receiver

Parametrised receiver for TTC Channel B broadcast commands. It sits between the TTC decoder and the trigger logic. It decodes fill-type, timestamp-reset and event-count-reset commands and can defer fill-type changes to a fill boundary. It also counts unrecognised commands with saturation and logs each one, with a timestamp, into a small FIFO that slow control reads out.

## Interface
- CMD_W, 6: width of broadcast command field; must satisfy CMD_W >= FT_W + 3
- FT_W, 2: fill-type width
- DEFAULT_FILL, 1: fill type after reset (muon fill)
- IMMEDIATE_FILL, 0: 1 = fill type applied on command; 0 = held pending until fill_apply
- CNT_W, 32: unknown-command counter width
- TS_W, 24: internal timestamp counter width
- LOG_AW, 4: log FIFO address width (depth 2^LOG_AW)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ttc_loopback  in  1  treated exactly as reset while high
- chan_b_info  in  CMD_W  broadcast command (Brcst[CMD_W+1:2])
- chan_b_valid  in  1  command strobe (BrcstStr), single cycle
- evt_count_reset  in  1  event-count reset from decoder
- fill_apply  in  1  fill-boundary strobe from trigger logic
- clear_status  in  1  clears unknown_cmd_count, error and overflow flags
- thres_unknown_ttc  in  CNT_W  error threshold
- fill_type  out  FT_W  active fill type
- fill_pending  out  1  pending fill type not yet applied
- reset_trig_num  out  1  event-number reset
- reset_trig_timestamp  out  1  timestamp reset
- unknown_cmd_count  out  CNT_W  saturating count of unknown commands
- error_unknown_ttc  out  1  count > threshold
- log_data  out  CMD_W+TS_W  {command, timestamp} of oldest entry
- log_valid  out  1  FIFO non-empty
- log_ready  in  1  consumer pop
- log_overflow  out  1  sticky: an entry was dropped

## Operation
- Decode, qualified by chan_b_valid:
  - TSR: info[CMD_W-1:CMD_W-3]==3'b001 and info[1]==1.
  - FILL: info[CMD_W-1]==1, info[1]==0, and code = info[CMD_W-2 -: FT_W] is nonzero. A zero code is ignored and counted as neither FILL nor unknown.
  - UNKNOWN: valid and not TSR, not FILL, not zero-code fill, and evt_count_reset low.
- reset_trig_num = evt_count_reset, combinational pass-through.
- reset_trig_timestamp: registered TSR decode.
- Fill handling, IMMEDIATE_FILL=1: on FILL, fill_type <= code; fill_pending stays 0.
- Fill handling, IMMEDIATE_FILL=0:
  - FILL writes pend_reg <= code and sets fill_pending.
  - fill_apply with fill_pending set: fill_type <= pend_reg, clear fill_pending.
  - fill_apply without pending: no change.
  - FILL and fill_apply in the same cycle: fill_type <= new code (bypass) and fill_pending stays 0.
  - A later FILL before apply overwrites pend_reg.
- Timestamp counter:
  - Free-running, wraps 2^TS_W-1 -> 0.
  - Cleared to 0 on the cycle after a TSR command.
- Unknown counter:
  - Each UNKNOWN increments unknown_cmd_count, saturating at 2^CNT_W-1.
  - clear_status zeroes it; if an UNKNOWN arrives on the same cycle, the result is 1.
  - error_unknown_ttc is registered (count > thres), evaluated on the updated count.
- Log FIFO:
  - Each UNKNOWN pushes {chan_b_info, timestamp}.
  - Pop when log_valid && log_ready.
  - Push while full with no pop: entry dropped, log_overflow set.
  - Push and pop while full: both performed, no overflow.
  - Push into empty: log_valid rises next cycle.
  - clear_status clears only log_overflow; FIFO contents are kept.
- Reset / ttc_loopback:
  - fill_type = DEFAULT_FILL, pend_reg = DEFAULT_FILL, fill_pending = 0.
  - reset_trig_timestamp = 0, timestamp = 0.
  - unknown_cmd_count = 0, error_unknown_ttc = 0.
  - FIFO empty, so log_valid = 0 and log_data = 0; log_overflow = 0.
  - Reset mid-operation discards pending fill and log contents.

## Timing
- All outputs are registered except reset_trig_num.
- Latency from chan_b_valid:
  - fill_type (immediate mode): 1 cycle.
  - reset_trig_timestamp: 1 cycle, high for 1 cycle.
  - unknown_cmd_count: 1 cycle; error_unknown_ttc: 1 cycle.
  - log_valid: 1 cycle.
- Latency from fill_apply to fill_type: 1 cycle.
- log_data is stable while log_valid is high and log_ready is low.
- Back-to-back chan_b_valid on every cycle must be handled with no lost counts.

## Test plan
- Reset, then idle 10 cycles -> fill_type=1, fill_pending=0, count=0, log_valid=0, reset_trig_timestamp=0.
- IMMEDIATE_FILL=0: info=6'b110000 -> fill_pending=1, fill_type=1; fill_apply -> fill_type=2, fill_pending=0. Then info=6'b101000 together with fill_apply -> fill_type=1, fill_pending=0.
- info=6'b001010 -> reset_trig_timestamp pulses 1 cycle later; the next logged unknown command has timestamp equal to the number of cycles elapsed since the clear.
- 3 unknowns (info=6'b000001) with thres=2 -> count 1,2,3; error rises when the count reaches 3; log holds 3 entries with info 000001; clear_status -> count=0, error=0, log_valid still 1.
- LOG_AW=2: 5 unknowns, no pop -> 4 entries, log_overflow=1; then push and pop while full -> stays at 4 entries, oldest entry removed.
- CNT_W=4, thres=15: 20 unknowns -> count saturates at 15, error=0; info=6'b100000 -> neither count nor fill_type changes.

Source files
------------

// File: rtl/ttc_chanb_cmd_receiver.sv
// TTC Channel B broadcast command receiver: fill-type, timestamp/event resets,
// saturating unknown-command counter and a timestamped log FIFO for slow control.
module ttc_chanb_cmd_receiver #(
  parameter int CMD_W          = 6,
  parameter int FT_W           = 2,
  parameter int DEFAULT_FILL   = 1,
  parameter int IMMEDIATE_FILL = 0,
  parameter int CNT_W          = 32,
  parameter int TS_W           = 24,
  parameter int LOG_AW         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ttc_loopback,
  input  logic [CMD_W-1:0]      chan_b_info,
  input  logic                  chan_b_valid,
  input  logic                  evt_count_reset,
  input  logic                  fill_apply,
  input  logic                  clear_status,
  input  logic [CNT_W-1:0]      thres_unknown_ttc,
  output logic [FT_W-1:0]       fill_type,
  output logic                  fill_pending,
  output logic                  reset_trig_num,
  output logic                  reset_trig_timestamp,
  output logic [CNT_W-1:0]      unknown_cmd_count,
  output logic                  error_unknown_ttc,
  output logic [CMD_W+TS_W-1:0] log_data,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic                  log_overflow
);
  localparam int LW    = CMD_W + TS_W;
  localparam int DEPTH = 1 << LOG_AW;
  localparam logic [FT_W-1:0] DEF_FT = FT_W'(DEFAULT_FILL);

  logic            w_rst;
  logic [FT_W-1:0] w_code;
  logic            w_tsr, w_fill_any, w_fill, w_unk;

  assign w_rst      = reset | ttc_loopback;
  assign w_code     = chan_b_info[CMD_W-2 -: FT_W];
  assign w_tsr      = chan_b_valid && (chan_b_info[CMD_W-1:CMD_W-3] == 3'b001) && chan_b_info[1];
  assign w_fill_any = chan_b_valid && chan_b_info[CMD_W-1] && !chan_b_info[1];
  assign w_fill     = w_fill_any && (w_code != '0);
  // Zero-code fill commands fall out of both FILL and UNKNOWN.
  assign w_unk      = chan_b_valid && !w_tsr && !w_fill_any && !evt_count_reset;

  assign reset_trig_num = evt_count_reset;

  logic [TS_W-1:0] r_ts;
  logic            r_tsr;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_ts  <= '0;
      r_tsr <= 1'b0;
    end else begin
      r_ts  <= w_tsr ? '0 : r_ts + 1'b1;
      r_tsr <= w_tsr;
    end
  end

  assign reset_trig_timestamp = r_tsr;

  logic [FT_W-1:0] r_fill_type, r_pend;
  logic            r_pending;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_fill_type <= DEF_FT;
      r_pend      <= DEF_FT;
      r_pending   <= 1'b0;
    end else if (IMMEDIATE_FILL != 0) begin
      if (w_fill) r_fill_type <= w_code;
      r_pending <= 1'b0;
    end else if (w_fill && fill_apply) begin
      // New code on the boundary cycle bypasses the pending register.
      r_fill_type <= w_code;
      r_pend      <= w_code;
      r_pending   <= 1'b0;
    end else if (w_fill) begin
      r_pend    <= w_code;
      r_pending <= 1'b1;
    end else if (fill_apply && r_pending) begin
      r_fill_type <= r_pend;
      r_pending   <= 1'b0;
    end
  end

  assign fill_type    = r_fill_type;
  assign fill_pending = r_pending;

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clear_status)                w_cnt_nxt = w_unk ? CNT_W'(1) : '0;
    else if (w_unk && r_cnt != '1)   w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= (w_cnt_nxt > thres_unknown_ttc);
    end
  end

  assign unknown_cmd_count = r_cnt;
  assign error_unknown_ttc = r_err;

  logic [LW-1:0]   r_mem [DEPTH];
  logic [LOG_AW:0] r_wr, r_rd;
  logic            r_ovf;
  logic            w_empty, w_full, w_pop, w_push;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[LOG_AW] != r_rd[LOG_AW]) && (r_wr[LOG_AW-1:0] == r_rd[LOG_AW-1:0]);
  assign w_pop   = !w_empty && log_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = w_unk && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[LOG_AW-1:0]] <= {chan_b_info, r_ts};
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_ovf <= (r_ovf && !clear_status) || (w_unk && !w_push);
    end
  end

  assign log_valid    = !w_empty;
  assign log_data     = w_empty ? '0 : r_mem[r_rd[LOG_AW-1:0]];
  assign log_overflow = r_ovf;
endmodule

// File: tb/tb_ttc_chanb_cmd_receiver.sv
// Bench for ttc_chanb_cmd_receiver: directed commands, log FIFO scoreboard
// popped by a monitor, plus direct status checks.
module tb_ttc_chanb_cmd_receiver;
  logic        clk = 0, reset = 1, ttc_loopback = 0, chan_b_valid = 0;
  logic        evt = 0, apply = 0, clr = 0, log_ready = 0;
  logic [5:0]  info = '0;
  logic [3:0]  thres = 4'd2;

  logic [1:0]  fill_type, fill_type_i;
  logic        pend, pend_i, rtn, rtn_i, rtt, rtt_i, err, err_i;
  logic        lv, lv_i, ovf, ovf_i;
  logic [3:0]  cnt, cnt_i;
  logic [29:0] ldata, ldata_i;

  ttc_chanb_cmd_receiver #(.CMD_W(6), .FT_W(2), .DEFAULT_FILL(1), .IMMEDIATE_FILL(0),
    .CNT_W(4), .TS_W(24), .LOG_AW(2)) dut (
    .clk(clk), .reset(reset), .ttc_loopback(ttc_loopback), .chan_b_info(info),
    .chan_b_valid(chan_b_valid), .evt_count_reset(evt), .fill_apply(apply),
    .clear_status(clr), .thres_unknown_ttc(thres), .fill_type(fill_type),
    .fill_pending(pend), .reset_trig_num(rtn), .reset_trig_timestamp(rtt),
    .unknown_cmd_count(cnt), .error_unknown_ttc(err), .log_data(ldata),
    .log_valid(lv), .log_ready(log_ready), .log_overflow(ovf));

  ttc_chanb_cmd_receiver #(.CMD_W(6), .FT_W(2), .DEFAULT_FILL(1), .IMMEDIATE_FILL(1),
    .CNT_W(4), .TS_W(24), .LOG_AW(2)) dut_i (
    .clk(clk), .reset(reset), .ttc_loopback(ttc_loopback), .chan_b_info(info),
    .chan_b_valid(chan_b_valid), .evt_count_reset(evt), .fill_apply(apply),
    .clear_status(clr), .thres_unknown_ttc(thres), .fill_type(fill_type_i),
    .fill_pending(pend_i), .reset_trig_num(rtn_i), .reset_trig_timestamp(rtt_i),
    .unknown_cmd_count(cnt_i), .error_unknown_ttc(err_i), .log_data(ldata_i),
    .log_valid(lv_i), .log_ready(log_ready), .log_overflow(ovf_i));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, cyc_tsr = 0;
  logic [29:0] exp_q[$];
  logic [29:0] e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One command cycle; the expected log entry's timestamp is the number of
  // edges since the edge after the last TSR.
  task automatic send(input logic [5:0] i, input bit exp_log);
    info = i; chan_b_valid = 1;
    if (i == 6'b001010) cyc_tsr = cyc;
    if (exp_log) exp_q.push_back({i, 24'(cyc - cyc_tsr - 1)});
    tick();
    chan_b_valid = 0; info = '0; apply = 0; clr = 0;
  endtask

  always @(negedge clk) begin
    if (!reset && !ttc_loopback && lv && log_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL log_pop: got %0h expected no entry", ldata);
      end else begin
        e = exp_q.pop_front();
        if (ldata !== e) begin
          n_bad++;
          $display("FAIL log_pop: got %0h expected %0h", ldata, e);
        end
      end
    end
  end

  initial begin
    idle(3);
    reset = 0;
    idle(10);
    chk("rst_fill", 32'(fill_type), 1);
    chk("rst_fill_i", 32'(fill_type_i), 1);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_lv", 32'(lv), 0);
    chk("rst_ldata", 32'(ldata), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_rtt", 32'(rtt), 0);
    chk("rst_rtn", 32'(rtn), 0);

    // deferred fill
    send(6'b110000, 0);
    chk("fill_pend", 32'(pend), 1);
    chk("fill_held", 32'(fill_type), 1);
    chk("fill_imm", 32'(fill_type_i), 2);
    apply = 1; tick(); apply = 0;
    chk("fill_apply", 32'(fill_type), 2);
    chk("fill_apply_pend", 32'(pend), 0);
    apply = 1; send(6'b101000, 0);
    chk("fill_bypass", 32'(fill_type), 1);
    chk("fill_bypass_pend", 32'(pend), 0);
    chk("fill_imm2", 32'(fill_type_i), 1);
    apply = 1; tick(); apply = 0;
    chk("apply_nopend", 32'(fill_type), 1);
    send(6'b110000, 0);
    send(6'b111000, 0);
    chk("overwrite_pend", 32'(pend), 1);
    chk("overwrite_held", 32'(fill_type), 1);
    apply = 1; tick(); apply = 0;
    chk("overwrite_apply", 32'(fill_type), 3);
    chk("fill_imm3", 32'(fill_type_i), 3);

    // event-count reset passes through and masks unknown counting
    evt = 1; info = 6'b000001; chan_b_valid = 1; #1;
    chk("rtn_pass", 32'(rtn), 1);
    tick(); evt = 0; chan_b_valid = 0; info = '0;
    chk("evt_not_unk", 32'(cnt), 0);
    chk("evt_no_log", 32'(lv), 0);

    // timestamp reset then unknowns
    send(6'b001010, 0);
    chk("rtt_pulse", 32'(rtt), 1);
    tick();
    chk("rtt_low", 32'(rtt), 0);
    idle(5);
    thres = 4'd2;
    send(6'b000001, 1);
    chk("unk_cnt1", 32'(cnt), 1);
    chk("unk_err1", 32'(err), 0);
    chk("unk_lv", 32'(lv), 1);
    chk("unk_ts", 32'(ldata[23:0]), 6);
    send(6'b000001, 1);
    chk("unk_cnt2", 32'(cnt), 2);
    chk("unk_err2", 32'(err), 0);
    send(6'b000001, 1);
    chk("unk_cnt3", 32'(cnt), 3);
    chk("unk_err3", 32'(err), 1);
    clr = 1; tick(); clr = 0;
    chk("clr_cnt", 32'(cnt), 0);
    chk("clr_err", 32'(err), 0);
    chk("clr_lv", 32'(lv), 1);

    // overflow with a 4-deep log
    send(6'b000001, 1);
    chk("full_noovf", 32'(ovf), 0);
    send(6'b000001, 0);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_cnt", 32'(cnt), 2);
    clr = 1; tick(); clr = 0;
    chk("ovf_clr", 32'(ovf), 0);
    chk("ovf_clr_lv", 32'(lv), 1);
    log_ready = 1; send(6'b000001, 1); log_ready = 0;
    chk("pushpop_noovf", 32'(ovf), 0);
    log_ready = 1; idle(4); log_ready = 0;
    chk("drain_lv", 32'(lv), 0);
    chk("drain_q", 32'(exp_q.size()), 0);

    // saturation and zero-code fill
    clr = 1; tick(); clr = 0;
    thres = 4'd15;
    log_ready = 1;
    repeat (20) send(6'b000001, 1);
    chk("sat_cnt", 32'(cnt), 15);
    chk("sat_err", 32'(err), 0);
    send(6'b100000, 0);
    chk("zero_cnt", 32'(cnt), 15);
    chk("zero_fill", 32'(fill_type), 3);
    chk("zero_fill_i", 32'(fill_type_i), 3);
    chk("zero_pend", 32'(pend), 0);
    idle(2); log_ready = 0;
    chk("sat_drain_lv", 32'(lv), 0);
    chk("sat_drain_q", 32'(exp_q.size()), 0);

    // loopback mid-operation acts as reset
    send(6'b110000, 0);
    send(6'b000001, 0);
    chk("pre_lb_pend", 32'(pend), 1);
    chk("pre_lb_lv", 32'(lv), 1);
    ttc_loopback = 1; tick(); ttc_loopback = 0;
    chk("lb_pend", 32'(pend), 0);
    chk("lb_fill", 32'(fill_type), 1);
    chk("lb_lv", 32'(lv), 0);
    chk("lb_ldata", 32'(ldata), 0);
    chk("lb_cnt", 32'(cnt), 0);
    apply = 1; tick(); apply = 0;
    chk("lb_apply", 32'(fill_type), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
